pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Control-side partner of the 5-bit program counter.
- Reads the current PC, fetches instructions from unified memory, and decodes them.
- Drives the counter's pc_write/next_pc pair for sequential increment, JMP and JZ.
- Issues data-memory requests and accumulator load strobes; multi-cycle, one instruction in flight.

Parameters:
- PC_W, 5: program counter / address width.
- DATA_W, 8: instruction and data word width.
- OP_W, 3: opcode field width; instruction = {opcode[7:5], operand[4:0]}.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_in  in  PC_W  current PC value from the program counter.
- pc_write  out  1  one-cycle PC write enable.
- next_pc  out  PC_W  value loaded into the PC when pc_write=1.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1=write, 0=read; valid while mem_req=1.
- mem_addr  out  PC_W  memory address; valid while mem_req=1.
- mem_wdata  out  DATA_W  store data (= acc_in) during STA.
- mem_rdata  in  DATA_W  read data; valid in the mem_ack cycle.
- mem_ack  in  1  request completion; one cycle; may arrive in the same cycle as mem_req.
- acc_in  in  DATA_W  accumulator value for STA.
- zero_flag  in  1  accumulator==0 flag, for JZ.
- acc_load  out  1  one-cycle accumulator load strobe.
- alu_op  out  2  00 pass (LDA), 01 add, 10 sub; valid with acc_load.
- ir_out  out  DATA_W  instruction register.
- halted  out  1  high in HALT state.

Behaviour:
- States, 3-bit encoding: FETCH, DECODE, MEM, HALT.
- Reset:
  - state=FETCH, ir=0.
  - pc_write, mem_req, mem_we, acc_load, halted, alu_op, next_pc all 0.
  - All strobes are forced to 0 in any cycle where reset=1.
  - A reset mid-request abandons the request; an ack arriving during reset is ignored.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=pc_in.
  - On mem_ack: ir<=mem_rdata; pc_write=1 with next_pc=pc_in+1, modulo 2^PC_W (31 -> 0); go to DECODE.
  - Without ack: stay in FETCH with outputs stable.
- DECODE (exactly one cycle), by ir[7:5]:
  - 000 NOP: go to FETCH.
  - 001 LDA, 011 ADD, 100 SUB: go to MEM as a read.
  - 010 STA: go to MEM as a write.
  - 101 JMP: pc_write=1, next_pc=ir[4:0]; go to FETCH.
  - 110 JZ: if zero_flag=1 then pc_write=1, next_pc=ir[4:0]; go to FETCH either way.
  - 111 HLT: go to HALT.
- MEM:
  - mem_req=1, mem_addr=ir[4:0], mem_we=(opcode==STA), mem_wdata=acc_in.
  - On mem_ack: for LDA/ADD/SUB, acc_load=1 with alu_op 00/01/10; for STA, no acc_load. Go to FETCH.
- HALT: halted=1; all strobes 0; leaves only via reset.
- Strobe rules:
  - pc_write is a single-cycle pulse, at most once per state visit.
  - pc_write is never asserted in MEM or HALT.
  - mem_ack outside FETCH/MEM is ignored.
- Latency with zero-wait memory:
  - NOP/JMP/JZ: 2 cycles.
  - LDA/ADD/SUB/STA: 3 cycles.
  - Each memory wait cycle adds 1.
- Ordering:
  - Because the PC register updates on the same edge, pc_in already holds the incremented value in DECODE.
  - JMP/JZ overwrite it in DECODE.
- Outputs are Moore-style from state/ir, except pc_write, next_pc and acc_load, which are qualified by mem_ack.

Decomposition:
- common/defines.vh holds:
  - opcode constants (OP_NOP..OP_HLT)
  - state encodings (S_FETCH, S_DECODE, S_MEM, S_HALT)
  - ALU op codes (ALU_PASS, ALU_ADD, ALU_SUB)
  - PC_W / DATA_W defaults
- One natural sub-module: insn_decode, combinational opcode to {is_mem, is_store, is_jump, is_cond, is_halt, alu_op}.
- The FSM and ir register stay in pc_sequencer.

Test Plan:
- Reset, then pc_in=0, memory[0]=0x00 (NOP), ack same cycle:
  - mem_req/mem_addr=0 in cycle 1; pc_write=1, next_pc=1 with the ack.
  - Back to FETCH after DECODE; halted=0.
- pc_in=31, NOP fetched: next_pc=0 (wrap).
- memory[2]=0xA9 (JMP 9), pc_in=2:
  - next_pc=3 pulse in FETCH.
  - next_pc=9 pulse in DECODE.
  - Next fetch mem_addr=9.
- JZ 0xC5 with zero_flag=0: no pc_write in DECODE. With zero_flag=1: next_pc=5.
- ADD 0x6C with mem_ack delayed 3 cycles in MEM:
  - mem_req held with mem_addr=12, mem_we=0.
  - acc_load=1, alu_op=01 only in the ack cycle.
- STA 0x47 with acc_in=0x5A: mem_we=1, mem_addr=7, mem_wdata=0x5A, acc_load=0.
- HLT 0xE0: halted=1 indefinitely, no requests even if mem_ack toggles.
- Reset asserted in MEM mid-wait: next cycle state=FETCH, all strobes 0 during reset.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// pc_sequencer_pkg
// Shared definitions for the program-counter sequencer: default widths,
// FSM state encoding, opcode values, ALU operation codes and the decoded
// instruction record produced by insn_decode.
// ---------------------------------------------------------------------------
package pc_sequencer_pkg;

    localparam int PC_W_DEF   = 5;
    localparam int DATA_W_DEF = 8;
    localparam int OP_W_DEF   = 3;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_MEM    = 3'd2,
        S_HALT   = 3'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_LDA = 3'b001,
        OP_STA = 3'b010,
        OP_ADD = 3'b011,
        OP_SUB = 3'b100,
        OP_JMP = 3'b101,
        OP_JZ  = 3'b110,
        OP_HLT = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        ALU_PASS = 2'b00,
        ALU_ADD  = 2'b01,
        ALU_SUB  = 2'b10
    } alu_op_t;

    typedef struct packed {
        logic    is_mem;    // needs a data-memory access
        logic    is_store;  // that access is a write
        logic    is_jump;   // loads the PC from the operand field
        logic    is_cond;   // jump only when the accumulator is zero
        logic    is_halt;
        alu_op_t alu_op;
    } decode_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// ---------------------------------------------------------------------------
// pc_sequencer_if
// Bundles every non-clock signal between the sequencer and its environment
// (program counter, unified memory, accumulator/ALU).
//   master : the sequencer (drives pc_write/next_pc, memory request, acc strobes)
//   slave  : the environment (drives pc_in, mem_rdata/mem_ack, acc_in, zero_flag)
// ---------------------------------------------------------------------------
interface pc_sequencer_if
    import pc_sequencer_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [PC_W-1:0]   pc_in;
    logic              pc_write;
    logic [PC_W-1:0]   next_pc;
    logic              mem_req;
    logic              mem_we;
    logic [PC_W-1:0]   mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic [DATA_W-1:0] acc_in;
    logic              zero_flag;
    logic              acc_load;
    logic [1:0]        alu_op;
    logic [DATA_W-1:0] ir_out;
    logic              halted;

    modport master (
        input  pc_in, mem_rdata, mem_ack, acc_in, zero_flag,
        output pc_write, next_pc, mem_req, mem_we, mem_addr, mem_wdata,
               acc_load, alu_op, ir_out, halted
    );

    modport slave (
        output pc_in, mem_rdata, mem_ack, acc_in, zero_flag,
        input  pc_write, next_pc, mem_req, mem_we, mem_addr, mem_wdata,
               acc_load, alu_op, ir_out, halted
    );
endinterface

// File: rtl/pc_sequencer_insn_decode.sv
// ---------------------------------------------------------------------------
// insn_decode
// Purely combinational opcode classifier.
//   opcode : instruction bits [7:5]
//   dec    : {is_mem, is_store, is_jump, is_cond, is_halt, alu_op}
// ---------------------------------------------------------------------------
module insn_decode
    import pc_sequencer_pkg::*;
(
    input  opcode_t opcode,
    output decode_t dec
);
    always_comb begin
        dec = '{is_mem: 1'b0, is_store: 1'b0, is_jump: 1'b0,
                is_cond: 1'b0, is_halt: 1'b0, alu_op: ALU_PASS};
        case (opcode)
            OP_LDA: dec.is_mem = 1'b1;
            OP_STA: begin
                dec.is_mem   = 1'b1;
                dec.is_store = 1'b1;
            end
            OP_ADD: begin
                dec.is_mem = 1'b1;
                dec.alu_op = ALU_ADD;
            end
            OP_SUB: begin
                dec.is_mem = 1'b1;
                dec.alu_op = ALU_SUB;
            end
            OP_JMP: dec.is_jump = 1'b1;
            OP_JZ: begin
                dec.is_jump = 1'b1;
                dec.is_cond = 1'b1;
            end
            OP_HLT: dec.is_halt = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Multi-cycle control unit sitting beside a PC_W-bit program counter.
// Fetches an instruction at pc_in, decodes it, performs at most one data
// memory access and strobes the accumulator; one instruction in flight.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; forces every strobe low while asserted
//   bus   : pc_sequencer_if.master (PC write pair, memory bus, acc strobes,
//           instruction register and halted flag)
// ---------------------------------------------------------------------------
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = OP_W_DEF
)(
    input logic           clk,
    input logic           reset,
    pc_sequencer_if.master bus
);
    state_t            state;
    logic [DATA_W-1:0] ir;
    logic              store_r;   // current MEM access is a write
    alu_op_t           alu_r;     // ALU op to issue when the MEM read completes
    opcode_t           ir_op;
    decode_t           dec;

    assign ir_op = opcode_t'(ir[DATA_W-1 -: OP_W]);

    insn_decode u_decode (
        .opcode (ir_op),
        .dec    (dec)
    );

    // State and instruction register
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_FETCH;
            ir      <= '0;
            store_r <= 1'b0;
            alu_r   <= ALU_PASS;
        end else begin
            case (state)
                S_FETCH: begin
                    if (bus.mem_ack) begin
                        ir    <= bus.mem_rdata;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    // Capture the access kind so MEM does not depend on the
                    // decoder staying valid.
                    store_r <= dec.is_store;
                    alu_r   <= dec.alu_op;
                    if (dec.is_halt)
                        state <= S_HALT;
                    else if (dec.is_mem)
                        state <= S_MEM;
                    else
                        state <= S_FETCH;
                end
                S_MEM: begin
                    if (bus.mem_ack)
                        state <= S_FETCH;
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

    // Output decode: Moore outputs from state/ir; pc_write, next_pc and
    // acc_load additionally qualified by mem_ack. Everything is held low
    // during reset so an ack arriving then has no effect.
    always_comb begin
        bus.pc_write  = 1'b0;
        bus.next_pc   = '0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.acc_load  = 1'b0;
        bus.alu_op    = ALU_PASS;
        bus.halted    = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    bus.mem_req  = 1'b1;
                    bus.mem_addr = bus.pc_in;
                    if (bus.mem_ack) begin
                        bus.pc_write = 1'b1;
                        // Natural PC_W-bit truncation gives the 31 -> 0 wrap.
                        bus.next_pc  = bus.pc_in + PC_W'(1);
                    end
                end
                S_DECODE: begin
                    // pc_in already holds the incremented value here; a
                    // taken jump overwrites it.
                    if (dec.is_jump && (!dec.is_cond || bus.zero_flag)) begin
                        bus.pc_write = 1'b1;
                        bus.next_pc  = ir[PC_W-1:0];
                    end
                end
                S_MEM: begin
                    bus.mem_req  = 1'b1;
                    bus.mem_addr = ir[PC_W-1:0];
                    bus.mem_we   = store_r;
                    if (store_r)
                        bus.mem_wdata = bus.acc_in;
                    if (bus.mem_ack && !store_r) begin
                        bus.acc_load = 1'b1;
                        bus.alu_op   = alu_r;
                    end
                end
                S_HALT:  bus.halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.ir_out = ir;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
// Drives pc_sequencer with a bench-side PC register and unified memory.
// Expected PC writes, ALU ops and memory transactions are queued when an
// instruction is set up and popped when the DUT produces the event.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    logic clk;
    logic reset;

    pc_sequencer_if #(.PC_W(5), .DATA_W(8)) bus ();

    pc_sequencer #(.PC_W(5), .DATA_W(8), .OP_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  mem [32];
    logic [4:0]  exp_pc  [$];
    logic [1:0]  exp_alu [$];
    logic [13:0] exp_req [$];   // {we, addr[4:0], wdata[7:0]}
    int          wait_q  [$];   // wait cycles per new request, in order

    logic req_active;
    int   wait_cnt;
    logic force_ack;

    logic       obs_req, obs_we, obs_pcw, obs_acc, obs_halt;
    logic [4:0] obs_addr, obs_npc;
    logic [7:0] obs_wdata;
    logic [1:0] obs_alu;

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
        end
    endtask

    // One clock cycle: respond to the bus at the falling edge, sample and
    // score the outputs, then advance the bench PC after the rising edge.
    task automatic step();
        @(negedge clk);
        bus.mem_ack = 1'b0;
        if (reset) begin
            req_active  = 1'b0;
            bus.mem_ack = force_ack;
        end else if (bus.mem_req) begin
            if (!req_active) begin
                req_active = 1'b1;
                wait_cnt   = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
            end
            if (wait_cnt == 0) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem[bus.mem_addr];
                if (bus.mem_we)
                    mem[bus.mem_addr] = bus.mem_wdata;
                req_active = 1'b0;
            end else begin
                wait_cnt--;
            end
        end else begin
            bus.mem_ack = force_ack;
        end
        #1;
        obs_req   = bus.mem_req;
        obs_we    = bus.mem_we;
        obs_addr  = bus.mem_addr;
        obs_wdata = bus.mem_wdata;
        obs_pcw   = bus.pc_write;
        obs_npc   = bus.next_pc;
        obs_acc   = bus.acc_load;
        obs_alu   = bus.alu_op;
        obs_halt  = bus.halted;
        if (obs_pcw) begin
            if (exp_pc.size() == 0) check("pc_write_unexpected", {31'd0, obs_pcw}, 32'd0);
            else                    check("next_pc", {27'd0, obs_npc}, {27'd0, exp_pc.pop_front()});
        end
        if (obs_acc) begin
            if (exp_alu.size() == 0) check("acc_load_unexpected", {31'd0, obs_acc}, 32'd0);
            else                     check("alu_op", {30'd0, obs_alu}, {30'd0, exp_alu.pop_front()});
        end
        if (obs_req && bus.mem_ack) begin
            if (exp_req.size() == 0) check("mem_req_unexpected", {31'd0, obs_req}, 32'd0);
            else check("mem_txn", {18'd0, obs_we, obs_addr, obs_wdata}, {18'd0, exp_req.pop_front()});
        end
        @(posedge clk);
        #1;
        if (obs_pcw)
            bus.pc_in = obs_npc;
        bus.mem_ack = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        reset         = 1'b1;
        force_ack     = 1'b0;
        req_active    = 1'b0;
        wait_cnt      = 0;
        bus.pc_in     = 5'd0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;
        bus.acc_in    = 8'h00;
        bus.zero_flag = 1'b0;

        // Reset, including an ack arriving during reset
        step();
        check("rst_mem_req",  {31'd0, obs_req},  32'd0);
        check("rst_pc_write", {31'd0, obs_pcw},  32'd0);
        check("rst_halted",   {31'd0, obs_halt}, 32'd0);
        force_ack = 1'b1;
        step();
        check("rst_ack_pcw",  {31'd0, obs_pcw},  32'd0);
        check("rst_acc_load", {31'd0, obs_acc},  32'd0);
        check("rst_alu_op",   {30'd0, obs_alu},  32'd0);
        check("rst_next_pc",  {27'd0, obs_npc},  32'd0);
        check("rst_ir",       {24'd0, bus.ir_out}, 32'd0);
        force_ack = 1'b0;
        reset     = 1'b0;

        // NOP at 0, zero-wait
        bus.pc_in = 5'd0; mem[0] = 8'h00;
        exp_req.push_back({1'b0, 5'd0, 8'h00}); exp_pc.push_back(5'd1);
        step();
        check("nop_req",  {31'd0, obs_req}, 32'd1);
        check("nop_addr", {27'd0, obs_addr}, 32'd0);
        check("nop_pcw",  {31'd0, obs_pcw}, 32'd1);
        step();
        check("nop_decode_req", {31'd0, obs_req}, 32'd0);
        check("nop_halted",     {31'd0, obs_halt}, 32'd0);

        // NOP at 31: PC wraps to 0
        bus.pc_in = 5'd31; mem[31] = 8'h00;
        exp_req.push_back({1'b0, 5'd31, 8'h00}); exp_pc.push_back(5'd0);
        step();
        check("wrap_next_pc", {27'd0, obs_npc}, 32'd0);
        step();

        // JMP 9 at 2, then the fetch from 9
        bus.pc_in = 5'd2; mem[2] = 8'hA9; mem[9] = 8'h00;
        exp_req.push_back({1'b0, 5'd2, 8'h00}); exp_pc.push_back(5'd3); exp_pc.push_back(5'd9);
        step();
        step();
        check("jmp_pcw", {31'd0, obs_pcw}, 32'd1);
        check("jmp_npc", {27'd0, obs_npc}, 32'd9);
        exp_req.push_back({1'b0, 5'd9, 8'h00}); exp_pc.push_back(5'd10);
        step();
        check("jmp_fetch_addr", {27'd0, obs_addr}, 32'd9);
        step();

        // JZ 5 not taken, then taken
        mem[10] = 8'hC5; bus.zero_flag = 1'b0;
        exp_req.push_back({1'b0, 5'd10, 8'h00}); exp_pc.push_back(5'd11);
        step();
        step();
        check("jz_nt_pcw", {31'd0, obs_pcw}, 32'd0);
        mem[11] = 8'hC5; bus.zero_flag = 1'b1;
        exp_req.push_back({1'b0, 5'd11, 8'h00}); exp_pc.push_back(5'd12); exp_pc.push_back(5'd5);
        step();
        step();
        check("jz_t_npc", {27'd0, obs_npc}, 32'd5);
        bus.zero_flag = 1'b0;

        // ADD 12 with three memory wait cycles
        mem[5] = 8'h6C; mem[12] = 8'h33;
        wait_q.push_back(0); wait_q.push_back(3);
        exp_req.push_back({1'b0, 5'd5, 8'h00}); exp_pc.push_back(5'd6);
        exp_req.push_back({1'b0, 5'd12, 8'h00}); exp_alu.push_back(2'b01);
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            check("add_wait_req",  {31'd0, obs_req}, 32'd1);
            check("add_wait_addr", {27'd0, obs_addr}, 32'd12);
            check("add_wait_we",   {31'd0, obs_we}, 32'd0);
            check("add_wait_acc",  {31'd0, obs_acc}, 32'd0);
        end
        step();
        check("add_acc_load", {31'd0, obs_acc}, 32'd1);
        check("add_alu_op",   {30'd0, obs_alu}, 32'd1);

        // STA 7 with acc_in = 0x5A
        bus.pc_in = 5'd6; mem[6] = 8'h47; bus.acc_in = 8'h5A;
        exp_req.push_back({1'b0, 5'd6, 8'h00}); exp_pc.push_back(5'd7);
        exp_req.push_back({1'b1, 5'd7, 8'h5A});
        step();
        step();
        step();
        check("sta_we",    {31'd0, obs_we}, 32'd1);
        check("sta_addr",  {27'd0, obs_addr}, 32'd7);
        check("sta_wdata", {24'd0, obs_wdata}, 32'h5A);
        check("sta_acc",   {31'd0, obs_acc}, 32'd0);
        check("sta_mem",   {24'd0, mem[7]}, 32'h5A);

        // LDA 3 and SUB 4, zero-wait
        bus.pc_in = 5'd8; mem[8] = 8'h23;
        exp_req.push_back({1'b0, 5'd8, 8'h00}); exp_pc.push_back(5'd9);
        exp_req.push_back({1'b0, 5'd3, 8'h00}); exp_alu.push_back(2'b00);
        step(); step(); step();
        check("lda_acc", {31'd0, obs_acc}, 32'd1);
        bus.pc_in = 5'd13; mem[13] = 8'h84;
        exp_req.push_back({1'b0, 5'd13, 8'h00}); exp_pc.push_back(5'd14);
        exp_req.push_back({1'b0, 5'd4, 8'h00}); exp_alu.push_back(2'b10);
        step(); step(); step();
        check("sub_acc", {31'd0, obs_acc}, 32'd1);

        // LDA 1 interrupted by reset while waiting in MEM
        bus.pc_in = 5'd14; mem[14] = 8'h21; mem[15] = 8'h00;
        wait_q.push_back(0); wait_q.push_back(5);
        exp_req.push_back({1'b0, 5'd14, 8'h00}); exp_pc.push_back(5'd15);
        step();
        step();
        step();
        check("mid_wait_req", {31'd0, obs_req}, 32'd1);
        reset = 1'b1; force_ack = 1'b1;
        step();
        check("mid_rst_req", {31'd0, obs_req}, 32'd0);
        check("mid_rst_pcw", {31'd0, obs_pcw}, 32'd0);
        check("mid_rst_acc", {31'd0, obs_acc}, 32'd0);
        reset = 1'b0; force_ack = 1'b0;
        exp_req.push_back({1'b0, 5'd15, 8'h00}); exp_pc.push_back(5'd16);
        step();
        check("post_rst_req",  {31'd0, obs_req}, 32'd1);
        check("post_rst_addr", {27'd0, obs_addr}, 32'd15);
        step();

        // HLT: stays halted while mem_ack toggles
        bus.pc_in = 5'd16; mem[16] = 8'hE0;
        exp_req.push_back({1'b0, 5'd16, 8'h00}); exp_pc.push_back(5'd17);
        step();
        step();
        check("hlt_decode_halted", {31'd0, obs_halt}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            force_ack = i[0];
            step();
            check("hlt_halted", {31'd0, obs_halt}, 32'd1);
            check("hlt_req",    {31'd0, obs_req}, 32'd0);
            check("hlt_pcw",    {31'd0, obs_pcw}, 32'd0);
        end
        force_ack = 1'b0;

        check("left_pc",  exp_pc.size(),  32'd0);
        check("left_alu", exp_alu.size(), 32'd0);
        check("left_req", exp_req.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
